// File: rtl/dijkstra_path_tracer_if.sv
// Valid/ready stream carrying the traced path, source node first.
interface dijkstra_path_tracer_if #(
    parameter int INDEX_WIDTH = 5
);
    logic                   valid;
    logic                   ready;
    logic [INDEX_WIDTH-1:0] node;
    logic                   last;

    modport master (output valid, output node, output last, input ready);
    modport slave  (input valid, input node, input last, output ready);
endinterface

// File: rtl/dijkstra_path_tracer.sv
// Walks a Dijkstra predecessor vector back from destination to source, stacking the
// nodes, then streams them out source-first; flags unreachable and looping vectors.
module dijkstra_path_tracer #(
    parameter int                     MAX_NODES        = 32,
    parameter int                     INDEX_WIDTH      = 5,
    parameter logic [INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = '1
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic                                   start_i,
    input  logic [INDEX_WIDTH-1:0]                 source_i,
    input  logic [INDEX_WIDTH-1:0]                 destination_i,
    input  logic [INDEX_WIDTH-1:0]                 number_of_nodes_i,
    input  logic [MAX_NODES-1:0][INDEX_WIDTH-1:0]  prev_vector_i,
    dijkstra_path_tracer_if.master                 path_if,
    output logic [INDEX_WIDTH:0]                   path_length_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   error_o
);
    localparam int SIW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK,
        ST_EMIT,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] src_q, src_d;
    logic [INDEX_WIDTH-1:0] nodes_q, nodes_d;
    logic [INDEX_WIDTH-1:0] cur_q, cur_d;
    logic [INDEX_WIDTH:0]   sp_q, sp_d;
    logic [INDEX_WIDTH:0]   len_q, len_d;
    logic [INDEX_WIDTH:0]   path_length_q, path_length_d;
    logic                   push_en;
    logic [INDEX_WIDTH-1:0] stack_q [MAX_NODES];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            src_q         <= '0;
            nodes_q       <= '0;
            cur_q         <= '0;
            sp_q          <= '0;
            len_q         <= '0;
            path_length_q <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            nodes_q       <= nodes_d;
            cur_q         <= cur_d;
            sp_q          <= sp_d;
            len_q         <= len_d;
            path_length_q <= path_length_d;
        end
    end

    // Stack contents need no reset: only entries below sp are ever read.
    always_ff @(posedge clock_i) begin
        if (push_en) begin
            stack_q[SIW'(sp_q)] <= cur_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        nodes_d       = nodes_q;
        cur_d         = cur_q;
        sp_d          = sp_q;
        len_d         = len_q;
        path_length_d = path_length_q;
        push_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d   = source_i;
                    nodes_d = number_of_nodes_i;
                    cur_d   = destination_i;
                    sp_d    = '0;
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                // A missing predecessor lands in cur and is rejected here, before use.
                if (cur_q >= nodes_q || cur_q == NO_PREVIOUS_NODE) begin
                    path_length_d = '0;
                    state_d       = ST_FAIL;
                end else if (sp_q == {1'b0, nodes_q}) begin
                    path_length_d = '0;
                    state_d       = ST_FAIL;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + 1'b1;
                    if (cur_q == src_q) begin
                        len_d   = sp_q + 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        cur_d = prev_vector_i[SIW'(cur_q)];
                    end
                end
            end
            ST_EMIT: begin
                if (path_if.ready) begin
                    sp_d = sp_q - 1'b1;
                    if (sp_q == 1) begin
                        path_length_d = len_q;
                        state_d       = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign path_if.valid = (state_q == ST_EMIT);
    assign path_if.node  = (state_q == ST_EMIT) ? stack_q[SIW'(sp_q - 1'b1)] : '0;
    assign path_if.last  = (state_q == ST_EMIT) && (sp_q == 1);
    assign path_length_o = path_length_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign error_o       = (state_q == ST_FAIL);
endmodule
